// File: rtl/ram_partitioned_gated.sv
// rtl/ram_partitioned_gated.sv - multi-port RAM split into independently power-gated partitions
//
// Purpose:
//   DEPTH x WIDTH register-file RAM with NUM_RD_PORTS read ports and
//   NUM_WR_PORTS write ports. The address space is divided into NUM_PARTS
//   partitions selected by the top NUM_PARTS_LOG address bits. Each partition
//   can be powered off; when powered back on it re-initialises itself one row
//   per cycle before accepting traffic again.
//
// Ports:
//   clk              - single clock
//   reset            - synchronous active-high reset
//   partitionGated_i - per-partition power-off request (1 = off)
//   addr_i           - read addresses, port r at [r*INDEX +: INDEX]
//   data_o           - read data, port r at [r*WIDTH +: WIDTH]
//   addrWr_i         - write addresses, port w at [w*INDEX +: INDEX]
//   dataWr_i         - write data, port w at [w*WIDTH +: WIDTH]
//   wrEn_i           - per-port write enable
//   partReady_o      - partition is initialised and serving traffic
//   ramReady_o       - every partition is either ready or gated off
//
// Configuration:
//   RAM_PART_READ_REG_EN - when defined, data_o is registered (one cycle of
//                          read latency); otherwise reads are combinational.

module ram_partitioned_gated #(
    parameter int DEPTH         = 64,
    parameter int INDEX         = 6,
    parameter int WIDTH         = 8,
    parameter int NUM_RD_PORTS  = 2,
    parameter int NUM_WR_PORTS  = 2,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2,
    parameter int RESET_SEQ     = 0,
    parameter int SEQ_START     = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PARTS-1:0]            partitionGated_i,
    input  logic [NUM_RD_PORTS*INDEX-1:0]   addr_i,
    output logic [NUM_RD_PORTS*WIDTH-1:0]   data_o,
    input  logic [NUM_WR_PORTS*INDEX-1:0]   addrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]   dataWr_i,
    input  logic [NUM_WR_PORTS-1:0]         wrEn_i,
    output logic [NUM_PARTS-1:0]            partReady_o,
    output logic                            ramReady_o
);

    localparam int ROWS     = DEPTH / NUM_PARTS;
    localparam int ROW_BITS = INDEX - NUM_PARTS_LOG;
    // A single-row partition still needs a 1-bit counter to stay legal.
    localparam int CNT_W    = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int PW       = (NUM_PARTS_LOG > 0) ? NUM_PARTS_LOG : 1;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]                  state    [NUM_PARTS];
    logic [CNT_W-1:0]            init_row [NUM_PARTS];
    logic [WIDTH-1:0]            mem      [DEPTH];
    logic [NUM_PARTS-1:0]        ready;
    logic [NUM_RD_PORTS*WIDTH-1:0] rd_data;

    // Partition number of an address: the bits above the row field.
    function automatic logic [PW-1:0] part_of(input logic [INDEX-1:0] a);
        logic [INDEX-1:0] s;
        s = a >> ROW_BITS;
        return s[PW-1:0];
    endfunction

    function automatic logic [INDEX-1:0] init_index(input int p, input logic [CNT_W-1:0] row);
        return INDEX'(p * ROWS + int'(row));
    endfunction

    function automatic logic [WIDTH-1:0] reset_value(input logic [INDEX-1:0] idx);
        if (RESET_SEQ != 0) begin
            return WIDTH'(SEQ_START + int'(idx));
        end
        return '0;
    endfunction

    // Per-partition power/initialisation sequencer.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            if (reset) begin
                state[p]    <= partitionGated_i[p] ? ST_OFF : ST_INIT;
                init_row[p] <= '0;
            end else begin
                case (state[p])
                    ST_INIT: begin
                        if (partitionGated_i[p]) begin
                            state[p] <= ST_OFF;
                        end else begin
                            init_row[p] <= init_row[p] + CNT_W'(1);
                            if (init_row[p] == CNT_W'(ROWS - 1)) begin
                                state[p] <= ST_READY;
                            end
                        end
                    end
                    ST_READY: begin
                        if (partitionGated_i[p]) begin
                            state[p] <= ST_OFF;
                        end
                    end
                    default: begin
                        // OFF (and any illegal encoding) restarts from row 0.
                        if (!partitionGated_i[p]) begin
                            state[p]    <= ST_INIT;
                            init_row[p] <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            ready[p] = (state[p] == ST_READY);
        end
    end

    // Storage. Init writes only target INIT partitions and user writes only
    // READY ones, so the two never collide. Iterating write ports in
    // ascending order lets the highest-numbered port win on equal addresses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                if (state[p] == ST_INIT && !partitionGated_i[p]) begin
                    mem[init_index(p, init_row[p])] <= reset_value(init_index(p, init_row[p]));
                end
            end
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (wrEn_i[w] && ready[part_of(addrWr_i[w*INDEX +: INDEX])]) begin
                    mem[addrWr_i[w*INDEX +: INDEX]] <= dataWr_i[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Read path: array is sampled before the edge, so a same-cycle write
    // is not visible. Non-ready partitions read as zero.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            if (ready[part_of(addr_i[r*INDEX +: INDEX])]) begin
                rd_data[r*WIDTH +: WIDTH] = mem[addr_i[r*INDEX +: INDEX]];
            end
        end
    end

`ifdef RAM_PART_READ_REG_EN
    logic [NUM_RD_PORTS*WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= rd_data;
        end
    end

    assign data_o = reset ? '0 : data_q;
`else
    assign data_o = reset ? '0 : rd_data;
`endif

    assign partReady_o = ready & {NUM_PARTS{~reset}};
    // A gated partition is not expected to be ready, so it must not hold
    // the whole-RAM ready indication low.
    assign ramReady_o  = &(partReady_o | partitionGated_i);

endmodule

// File: tb/tb_ram_partitioned_gated.sv
// tb/tb_ram_partitioned_gated.sv - self-checking bench for ram_partitioned_gated
module tb_ram_partitioned_gated;

    localparam int ROWS  = 16;
    localparam int NP    = 4;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  gated;
    logic [5:0]  ra [2];
    logic [5:0]  wa [2];
    logic [7:0]  wd [2];
    logic [1:0]  we;
    logic [11:0] addr_bus;
    logic [11:0] addr_wr_bus;
    logic [15:0] data_wr_bus;
    logic [15:0] data_bus;
    logic [3:0]  part_ready;
    logic        ram_ready;

    assign addr_bus    = {ra[1], ra[0]};
    assign addr_wr_bus = {wa[1], wa[0]};
    assign data_wr_bus = {wd[1], wd[0]};

    ram_partitioned_gated #(
        .DEPTH(64), .INDEX(6), .WIDTH(8), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2),
        .NUM_PARTS(4), .NUM_PARTS_LOG(2), .RESET_SEQ(1), .SEQ_START(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .partitionGated_i(gated),
        .addr_i(addr_bus),
        .data_o(data_bus),
        .addrWr_i(addr_wr_bus),
        .dataWr_i(data_wr_bus),
        .wrEn_i(we),
        .partReady_o(part_ready),
        .ramReady_o(ram_ready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: contents plus, per partition, cycles left until
    // ready (0 = ready, >0 = initialising, -1 = powered off).
    logic [7:0] mm [DEPTH];
    int         left [NP];

    logic [7:0] obs [2];
    logic [3:0] obs_part;
    logic       obs_ready;

    function automatic logic [7:0] rv(input int i);
        return 8'(5 + i);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            for (int p = 0; p < NP; p++) left[p] = gated[p] ? -1 : ROWS;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (we[w] && left[int'(wa[w]) / ROWS] == 0) mm[wa[w]] = wd[w];
            end
            for (int p = 0; p < NP; p++) begin
                if (left[p] == 0) begin
                    if (gated[p]) left[p] = -1;
                end else if (left[p] > 0) begin
                    if (gated[p]) begin
                        left[p] = -1;
                    end else begin
                        left[p] = left[p] - 1;
                        if (left[p] == 0) begin
                            for (int i = 0; i < ROWS; i++) mm[p*ROWS + i] = rv(p*ROWS + i);
                        end
                    end
                end else if (!gated[p]) begin
                    left[p] = ROWS;
                end
            end
        end
    endtask

    // Inputs are set just after a rising edge; this checks the cycle and
    // returns just after the next rising edge with the model advanced.
    task automatic run_cycle();
        logic [7:0] e [2];
        logic [3:0] ep;
        #1;
        for (int p = 0; p < NP; p++) ep[p] = !reset && left[p] == 0;
        for (int r = 0; r < 2; r++) begin
            e[r] = (!reset && left[int'(ra[r]) / ROWS] == 0) ? mm[ra[r]] : 8'h00;
        end
        obs_part  = part_ready;
        obs_ready = ram_ready;
        check("part_ready", part_ready, ep);
        check("ram_ready", ram_ready, &(ep | gated));
`ifndef RAM_PART_READ_REG_EN
        obs[0] = data_bus[7:0];
        obs[1] = data_bus[15:8];
        check("rd0", obs[0], e[0]);
        check("rd1", obs[1], e[1]);
`endif
        @(posedge clk);
        #1;
`ifdef RAM_PART_READ_REG_EN
        obs[0] = data_bus[7:0];
        obs[1] = data_bus[15:8];
        check("rd0", obs[0], e[0]);
        check("rd1", obs[1], e[1]);
`endif
        model_update();
    endtask

    typedef struct {
        logic       we0;
        logic [5:0] a0;
        logic [7:0] d0;
        logic       we1;
        logic [5:0] a1;
        logic [7:0] d1;
        logic [5:0] r0;
        logic [5:0] r1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t tbl [8];
    int   cnt;

    initial begin
        tbl[0] = '{1'b1, 6'd7,  8'hAA, 1'b1, 6'd7,  8'h55, 6'd7,  6'd20, 8'h0C, 8'h19};
        tbl[1] = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  8'h00, 6'd7,  6'd63, 8'h55, 8'h44};
        tbl[2] = '{1'b1, 6'd3,  8'h11, 1'b1, 6'd40, 8'h3C, 6'd3,  6'd40, 8'h08, 8'h2D};
        tbl[3] = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  8'h00, 6'd3,  6'd40, 8'h11, 8'h3C};
        tbl[4] = '{1'b1, 6'd0,  8'hFF, 1'b1, 6'd1,  8'h01, 6'd0,  6'd1,  8'h05, 8'h06};
        tbl[5] = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  8'h00, 6'd0,  6'd1,  8'hFF, 8'h01};
        tbl[6] = '{1'b0, 6'd10, 8'h99, 1'b1, 6'd10, 8'h77, 6'd10, 6'd63, 8'h0F, 8'h44};
        tbl[7] = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  8'h00, 6'd10, 6'd7,  8'h77, 8'h55};

        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
        for (int p = 0; p < NP; p++) left[p] = ROWS;
        reset = 1'b1; gated = 4'h0; we = 2'b00;
        ra[0] = 6'd20; ra[1] = 6'd63; wa[0] = 6'd0; wa[1] = 6'd0; wd[0] = 8'h00; wd[1] = 8'h00;

        // One-cycle reset, then ready exactly ROWS cycles later.
        run_cycle();
        check("reset_part_ready", obs_part, 4'h0);
        check("reset_rd0_zero", obs[0], 8'h00);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            if (obs_ready) break;
            cnt++;
        end
        check("reset_to_ready_cycles", cnt, 16);
        check("init_rd20", obs[0], 8'd25);
        check("init_rd63", obs[1], 8'd68);

        // Table-driven write/read vectors.
        for (int i = 0; i < 8; i++) begin
            we    = {tbl[i].we1, tbl[i].we0};
            wa[0] = tbl[i].a0; wd[0] = tbl[i].d0;
            wa[1] = tbl[i].a1; wd[1] = tbl[i].d1;
            ra[0] = tbl[i].r0; ra[1] = tbl[i].r1;
            run_cycle();
            check($sformatf("tbl%0d_rd0", i), obs[0], tbl[i].e0);
            check($sformatf("tbl%0d_rd1", i), obs[1], tbl[i].e1);
        end
        we = 2'b00;

        // Gate partition 2, others keep serving.
        ra[0] = 6'd40; ra[1] = 6'd10; gated = 4'b0100;
        run_cycle();
        check("gate_pre_rd40", obs[0], 8'h3C);
        run_cycle();
        check("gated_part_ready2", obs_part[2], 1'b0);
        check("gated_rd40", obs[0], 8'h00);
        check("gated_rd10", obs[1], 8'h77);
        check("gated_ram_ready", obs_ready, 1'b1);
        we = 2'b11; wa[0] = 6'd41; wd[0] = 8'h99; wa[1] = 6'd11; wd[1] = 8'h66;
        run_cycle();
        we = 2'b00; ra[1] = 6'd11;
        run_cycle();
        check("gated_other_write", obs[1], 8'h66);
        gated = 4'h0;
        run_cycle();
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            if (obs_part[2]) break;
            cnt++;
        end
        check("ungate_init_cycles", cnt, 16);
        check("reinit_rd40", obs[0], 8'd45);

        // Write during partition-1 init is dropped.
        gated = 4'b0010;
        run_cycle();
        gated = 4'h0;
        run_cycle();
        we = 2'b01; wa[0] = 6'd20; wd[0] = 8'hEE; ra[0] = 6'd20;
        repeat (3) run_cycle();
        we = 2'b00;
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            if (obs_part[1]) break;
        end
        check("init_done_p1", obs_part[1], 1'b1);
        check("init_write_dropped", obs[0], 8'd25);

        // Reset reasserted mid-init restarts the sequence.
        we = 2'b01; wa[0] = 6'd7; wd[0] = 8'hC3;
        run_cycle();
        we = 2'b00; ra[0] = 6'd7;
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        repeat (8) run_cycle();
        check("mid_init_not_ready", obs_ready, 1'b0);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            if (obs_ready) break;
            cnt++;
        end
        check("restart_to_ready_cycles", cnt, 16);
        check("restart_rd7", obs[0], 8'd12);

        // Randomised traffic with occasional gating and reset.
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 59) == 0) gated[p] = ~gated[p];
            end
            reset = ($urandom_range(0, 299) == 0);
            we    = 2'($urandom_range(0, 3));
            wa[0] = 6'($urandom_range(0, 63));
            wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : 6'($urandom_range(0, 63));
            wd[0] = 8'($urandom_range(0, 255));
            wd[1] = 8'($urandom_range(0, 255));
            ra[0] = ($urandom_range(0, 3) == 0) ? wa[0] : 6'($urandom_range(0, 63));
            ra[1] = 6'($urandom_range(0, 63));
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_partitioned_gated.md
RAM_PARTITIONED_GATED -- requirements
Module: ram_partitioned_gated

Interface
REQ-001 SHALL have parameter DEPTH, default 64, total entries (power of two).
REQ-002 SHALL have parameter INDEX, default 6, log2(DEPTH).
REQ-003 SHALL have parameter WIDTH, default 8, entry width in bits.
REQ-004 SHALL have parameters NUM_RD_PORTS, default 2, and NUM_WR_PORTS, default 2.
REQ-005 SHALL have parameters NUM_PARTS, default 4 (power of two, 1..DEPTH), and NUM_PARTS_LOG, default 2.
REQ-006 SHALL have parameter RESET_SEQ, default 0: 0 = init to zero, 1 = init to (SEQ_START + global index) mod 2^WIDTH.
REQ-007 SHALL have parameter SEQ_START, default 0.
REQ-008 SHALL have port clk, in, 1, the single clock.
REQ-009 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-010 SHALL have port partitionGated_i, in, NUM_PARTS, 1 = partition powered off.
REQ-011 SHALL have port addr_i, in, NUM_RD_PORTS x INDEX, binary read address.
REQ-012 SHALL have port data_o, out, NUM_RD_PORTS x WIDTH, read data.
REQ-013 SHALL have port addrWr_i, in, NUM_WR_PORTS x INDEX, binary write address.
REQ-014 SHALL have port dataWr_i, in, NUM_WR_PORTS x WIDTH, write data.
REQ-015 SHALL have port wrEn_i, in, NUM_WR_PORTS, per-port write enable.
REQ-016 SHALL have port partReady_o, out, NUM_PARTS, partition in READY.
REQ-017 SHALL have port ramReady_o, out, 1, all ungated partitions READY.

Function
REQ-018 Address partition field SHALL be addr[INDEX-1:INDEX-NUM_PARTS_LOG]; row = remaining low bits; ROWS = DEPTH/NUM_PARTS.
REQ-019 Each partition SHALL run a FSM with states OFF, INIT, READY and an init row counter of log2(ROWS) bits.
REQ-020 INIT: each cycle SHALL write the reset value to the row at the counter and increment it; after row ROWS-1 SHALL enter READY next cycle (ROWS cycles in INIT).
REQ-021 READY with partitionGated_i=1 SHALL enter OFF next cycle; INIT with gated=1 SHALL abort to OFF.
REQ-022 OFF with gated=0 SHALL enter INIT with counter 0; contents of an OFF partition are undefined until reinitialised.
REQ-023 Writes SHALL commit at clk edge only when wrEn_i=1 and the target partition is READY; all other writes SHALL be dropped silently.
REQ-024 Same-cycle writes to one address SHALL resolve to the highest-numbered port.
REQ-025 Reads SHALL be combinational (absent REQ-033); reading during a write to the same address SHALL return the old data.
REQ-026 A read of a partition not in READY SHALL return all zeros.
REQ-027 ramReady_o SHALL equal AND over partitions p of (partReady_o[p] | partitionGated_i[p]); registered with state, no combinational path from partitionGated_i except this OR term.
REQ-028 Gating changes SHALL affect only their own partition; other partitions keep contents and serve reads/writes uninterrupted.

Reset
REQ-029 During reset, every partition SHALL load INIT with counter 0 if ungated, else OFF.
REQ-030 During reset, partReady_o SHALL be 0 and writes dropped; after reset deasserts, ramReady_o SHALL rise ROWS cycles later.
REQ-031 Reset asserted mid-INIT SHALL restart INIT from row 0.
REQ-032 data_o SHALL be 0 while reset is asserted.

Configuration
REQ-033 Macro RAM_PART_READ_REG_EN defined: data_o SHALL be registered (1-cycle latency, reset to 0, zero-gating per REQ-026 applied to the state at sample time); undefined: data_o combinational per REQ-025.

Verification
REQ-034 Defaults, RESET_SEQ=1, SEQ_START=5; 1-cycle reset -> ramReady_o low 16 cycles then high; read addr 20 -> 25, addr 63 -> 68.
REQ-035 Same cycle: port0 wr addr 7 = 0xAA, port1 wr addr 7 = 0x55 -> next cycle read addr 7 = 0x55.
REQ-036 Write addr 40 = 0x3C, gate partition 2 -> partReady_o[2]=0, read addr 40 = 0, addr 10 unchanged, ramReady_o stays 1; ungate -> partReady_o[2] low 16 cycles, then addr 40 = reset value (45).
REQ-037 Write addr 20 during partition-1 INIT -> dropped, addr 20 = reset value after INIT.
REQ-038 Reset reasserted 8 cycles into INIT -> ramReady_o rises 16 cycles after final deassert.
REQ-039 With RAM_PART_READ_REG_EN: write addr 3 = 0x11, read addr 3 next cycle -> data_o = 0x11 one cycle after address applied.
